// File: rtl/spi_master_if.sv
// Host/serial bundle for the byte-wide SPI master.
// The master modport is the controller's view; the slave modport is the view of
// whatever sits around it (host logic plus the SPI slave on the serial pins).
interface spi_master_if;
    logic       i_start;
    logic [7:0] i_tdata;
    logic       i_mlb;
    logic       i_sdin;
    logic       o_ss;
    logic       o_sck;
    logic       o_sdout;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_rdata;

    modport master (
        input  i_start, i_tdata, i_mlb, i_sdin,
        output o_ss, o_sck, o_sdout, o_busy, o_done, o_rdata
    );

    modport slave (
        output i_start, i_tdata, i_mlb, i_sdin,
        input  o_ss, o_sck, o_sdout, o_busy, o_done, o_rdata
    );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master: sck idles high, data launched after each sck fall and
// sampled on each sck rise, MSB- or LSB-first per frame. All outputs registered.
module spi_master #(
    parameter int unsigned CLK_DIV = 4  // clk cycles per sck half-period, 1..255
) (
    input  logic          i_clk,
    input  logic          i_rstb,
    spi_master_if.master  io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftLo,
        StShiftHi,
        StHold,
        StDone
    } state_e;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_e     r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic       r_mlb;
    logic       r_ss;
    logic       r_sck;
    logic       r_sdout;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;

    logic       w_div_end;
    logic       w_tx_bit;

    // Divider terminal count and the bit currently at the transmit end of the shifter.
    always_comb begin
        w_div_end = (r_div == DIV_MAX);
        w_tx_bit  = r_mlb ? r_tx[7] : r_tx[0];
    end

    // Frame sequencer with registered serial and handshake outputs.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_state   <= StIdle;
            r_div     <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_mlb     <= 1'b0;
            r_ss      <= 1'b1;
            r_sck     <= 1'b1;
            r_sdout   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            case (r_state)
                StIdle: begin
                    r_div <= 8'd0;
                    if (io_bus.i_start) begin
                        r_tx      <= io_bus.i_tdata;
                        r_mlb     <= io_bus.i_mlb;
                        r_rx      <= 8'h00;
                        r_bit_cnt <= 3'd0;
                        r_ss      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= StSetup;
                    end
                end
                StSetup: begin
                    if (w_div_end) begin
                        r_div   <= 8'd0;
                        r_sck   <= 1'b0;
                        r_sdout <= w_tx_bit;
                        r_state <= StShiftLo;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                StShiftLo: begin
                    if (w_div_end) begin
                        r_div     <= 8'd0;
                        r_sck     <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        // Rx and tx move in the same direction so the next tx bit
                        // is always at the same end as the first.
                        if (r_mlb) begin
                            r_rx <= {r_rx[6:0], io_bus.i_sdin};
                            r_tx <= {r_tx[6:0], 1'b0};
                        end else begin
                            r_rx <= {io_bus.i_sdin, r_rx[7:1]};
                            r_tx <= {1'b0, r_tx[7:1]};
                        end
                        r_state <= StShiftHi;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                StShiftHi: begin
                    if (w_div_end) begin
                        r_div <= 8'd0;
                        // The 3-bit counter wraps to zero once all eight bits are in.
                        if (r_bit_cnt == 3'd0) begin
                            r_state <= StHold;
                        end else begin
                            r_sck   <= 1'b0;
                            r_sdout <= w_tx_bit;
                            r_state <= StShiftLo;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                StHold: begin
                    if (w_div_end) begin
                        r_div   <= 8'd0;
                        r_ss    <= 1'b1;
                        r_done  <= 1'b1;
                        r_sdout <= 1'b0;
                        r_rdata <= r_rx;
                        r_state <= StDone;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Drive the bus straight from the registers.
    always_comb begin
        io_bus.o_ss    = r_ss;
        io_bus.o_sck   = r_sck;
        io_bus.o_sdout = r_sdout;
        io_bus.o_busy  = r_busy;
        io_bus.o_done  = r_done;
        io_bus.o_rdata = r_rdata;
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 4, 1, 2) share host stimulus and
// are compared every cycle against a frame-offset model, plus literal frame checks.
module tb_spi_master;

    localparam int DIV [3] = '{4, 1, 2};
    localparam logic [1:0] MODE_SLAVE = 2'd0;  // sdin from a model slave sending resp
    localparam logic [1:0] MODE_LOOP  = 2'd1;  // sdin looped from sdout
    localparam logic [1:0] MODE_ZERO  = 2'd2;  // sdin tied low

    logic       clk = 1'b0;
    logic       rstb;
    logic       start = 1'b0;
    logic       mlb = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic [7:0] resp = 8'h00;
    logic [1:0] mode = MODE_LOOP;
    logic [2:0] sdin_drv = 3'b000;

    logic [2:0] w_ss, w_sck, w_sdout, w_busy, w_done;
    logic [7:0] w_rdata [3];

    int tests = 0;
    int fails = 0;

    // Model: a frame is just an offset k from the accepting edge.
    bit         m_act [3];
    int         m_k [3];
    logic [7:0] m_tx [3];
    logic [7:0] m_resp [3];
    logic [7:0] m_exp_rx [3];
    logic [7:0] m_rdata [3];
    logic       m_mlb [3];

    // Observations for the literal checks.
    int         mon_low [3];
    int         mon_rise [3];
    int         mon_done [3];
    int         mon_busy [3];
    int         hi_run [3];
    int         last_gap [3];
    logic [7:0] mon_bits [3];
    logic       prev_sck [3];
    logic       prev_ss [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        spi_master_if u_if ();
        assign u_if.i_start = start;
        assign u_if.i_tdata = tdata;
        assign u_if.i_mlb   = mlb;
        assign u_if.i_sdin  = (mode == MODE_LOOP) ? u_if.o_sdout :
                              (mode == MODE_ZERO) ? 1'b0 : sdin_drv[g];
        spi_master #(.CLK_DIV(DIV[g])) u_dut (
            .i_clk  (clk),
            .i_rstb (rstb),
            .io_bus (u_if.master)
        );
        assign w_ss[g]    = u_if.o_ss;
        assign w_sck[g]   = u_if.o_sck;
        assign w_sdout[g] = u_if.o_sdout;
        assign w_busy[g]  = u_if.o_busy;
        assign w_done[g]  = u_if.o_done;
        assign w_rdata[g] = u_if.o_rdata;
    end

    task automatic check(input string name, input int g, input logic [7:0] got,
                         input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d (div %0d): got %02h, expected %02h at %0t",
                     name, g, DIV[g], got, exp, $time);
        end
    endtask

    function automatic logic txbit(input int g, input int b);
        if (m_mlb[g]) return m_tx[g][7 - b];
        return m_tx[g][b];
    endfunction

    task automatic step_model(input int g);
        int d;
        d = DIV[g];
        if (!rstb) begin
            m_act[g]   = 1'b0;
            m_k[g]     = 0;
            m_rdata[g] = 8'h00;
        end else if (m_act[g]) begin
            if (m_k[g] == 18 * d) begin
                m_act[g] = 1'b0;
            end else begin
                m_k[g]++;
                if (m_k[g] == 18 * d) m_rdata[g] = m_exp_rx[g];
            end
        end else if (start) begin
            m_act[g]  = 1'b1;
            m_k[g]    = 0;
            m_tx[g]   = tdata;
            m_mlb[g]  = mlb;
            m_resp[g] = resp;
            m_exp_rx[g] = (mode == MODE_LOOP) ? tdata : (mode == MODE_ZERO) ? 8'h00 : resp;
        end
    endtask

    task automatic compare(input int g);
        int d, k, b;
        logic e_ss, e_sck, e_sdout, e_busy, e_done;
        d = DIV[g];
        k = m_k[g];
        e_ss = 1'b1; e_sck = 1'b1; e_sdout = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_act[g]) begin
            e_busy = 1'b1;
            if (k == 18 * d) begin
                e_done = 1'b1;
            end else begin
                e_ss = 1'b0;
                // Setup d cycles, then 16 half-periods (low first), then hold d cycles.
                if (k >= d && k < 17 * d) e_sck = (((k - d) / d) % 2) == 1;
                if (k >= d) begin
                    b = (k - d) / (2 * d);
                    if (b > 7) b = 7;
                    e_sdout = txbit(g, b);
                end
            end
        end
        check("ss", g, 8'(w_ss[g]), 8'(e_ss));
        check("sck", g, 8'(w_sck[g]), 8'(e_sck));
        check("sdout", g, 8'(w_sdout[g]), 8'(e_sdout));
        check("busy", g, 8'(w_busy[g]), 8'(e_busy));
        check("done", g, 8'(w_done[g]), 8'(e_done));
        check("rdata", g, w_rdata[g], m_rdata[g]);
    endtask

    task automatic monitor(input int g);
        if (!w_ss[g]) mon_low[g]++;
        if (!w_ss[g] && w_sck[g] && !prev_sck[g]) begin
            mon_rise[g]++;
            mon_bits[g] = {mon_bits[g][6:0], w_sdout[g]};
        end
        if (w_done[g]) mon_done[g]++;
        if (w_busy[g]) mon_busy[g]++;
        if (w_ss[g]) begin
            hi_run[g]++;
        end else begin
            if (prev_ss[g]) last_gap[g] = hi_run[g];
            hi_run[g] = 0;
        end
        prev_sck[g] = w_sck[g];
        prev_ss[g]  = w_ss[g];
    endtask

    // Model slave: present bit b of resp for the whole of bit b's sck period.
    task automatic drive_sdin(input int g);
        int d, k, b;
        d = DIV[g];
        k = m_k[g];
        if (m_act[g] && k >= d && k < 17 * d) begin
            b = (k - d) / (2 * d);
            sdin_drv[g] = m_mlb[g] ? m_resp[g][7 - b] : m_resp[g][b];
        end else begin
            sdin_drv[g] = 1'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            step_model(g);
            compare(g);
            monitor(g);
            drive_sdin(g);
        end
    endtask

    task automatic clr_mon();
        for (int g = 0; g < 3; g++) begin
            mon_low[g] = 0; mon_rise[g] = 0; mon_done[g] = 0; mon_busy[g] = 0;
            mon_bits[g] = 8'h00;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((m_act[0] || m_act[1] || m_act[2]) && n < bound) begin
            cycle();
            n++;
        end
        tests++;
        if (m_act[0] || m_act[1] || m_act[2]) begin
            fails++;
            $display("FAIL idle_wait: frame still open after %0d cycles", bound);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int g = 0; g < 3; g++) begin
            m_act[g] = 1'b0; m_k[g] = 0; m_tx[g] = 8'h00; m_resp[g] = 8'h00;
            m_exp_rx[g] = 8'h00; m_rdata[g] = 8'h00; m_mlb[g] = 1'b0;
            hi_run[g] = 0; last_gap[g] = 0; prev_sck[g] = 1'b1; prev_ss[g] = 1'b1;
        end
        clr_mon();
        rstb = 1'b0;
        repeat (3) cycle();
        rstb = 1'b1;
        repeat (2) cycle();

        // Loopback MSB-first 0x7C.
        clr_mon();
        mode = MODE_LOOP; mlb = 1'b1; tdata = 8'h7C;
        pulse_start();
        wait_idle(200);
        check("t1_bits", 0, mon_bits[0], 8'h7C);
        check("t1_rise", 0, 8'(mon_rise[0]), 8'd8);
        check("t1_ss_low", 0, 8'(mon_low[0]), 8'd72);
        check("t1_done", 0, 8'(mon_done[0]), 8'd1);
        check("t1_busy", 0, 8'(mon_busy[0]), 8'd73);
        check("t1_rdata", 0, w_rdata[0], 8'h7C);
        repeat (3) cycle();

        // LSB-first 0x70 against a slave returning 0xA5.
        clr_mon();
        mode = MODE_SLAVE; mlb = 1'b0; tdata = 8'h70; resp = 8'hA5;
        pulse_start();
        wait_idle(200);
        check("t2_bits", 0, mon_bits[0], 8'h0E);
        check("t2_rdata", 0, w_rdata[0], 8'hA5);
        check("t2_rdata", 2, w_rdata[2], 8'hA5);
        repeat (3) cycle();

        // Divide-by-1, 0xFF out, sdin low.
        clr_mon();
        mode = MODE_ZERO; mlb = 1'b1; tdata = 8'hFF;
        pulse_start();
        wait_idle(200);
        check("t3_ss_low", 1, 8'(mon_low[1]), 8'd18);
        check("t3_rise", 1, 8'(mon_rise[1]), 8'd8);
        check("t3_bits", 1, mon_bits[1], 8'hFF);
        check("t3_done", 1, 8'(mon_done[1]), 8'd1);
        check("t3_rdata", 1, w_rdata[1], 8'h00);
        repeat (3) cycle();

        // Start held high for 150 edges, data/order scrambled every cycle.
        clr_mon();
        mode = MODE_LOOP;
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tdata = 8'($urandom);
            mlb = 1'($urandom);
            cycle();
        end
        start = 1'b0;
        wait_idle(200);
        check("t4_gap", 2, 8'(last_gap[2]), 8'd2);
        check("t4_gap", 0, 8'(last_gap[0]), 8'd2);
        check("t4_frames", 2, 8'(mon_done[2]), 8'd4);
        check("t4_frames", 0, 8'(mon_done[0]), 8'd3);
        check("t4_frames", 1, 8'(mon_done[1]), 8'd8);
        repeat (3) cycle();

        // tdata changes mid-frame.
        clr_mon();
        mode = MODE_LOOP; mlb = 1'b1; tdata = 8'h3C;
        pulse_start();
        repeat (10) cycle();
        tdata = 8'hC3;
        wait_idle(200);
        check("t5_bits", 0, mon_bits[0], 8'h3C);
        check("t5_rdata", 0, w_rdata[0], 8'h3C);
        repeat (3) cycle();

        // Random frames with random start chatter during the frame.
        for (int f = 0; f < 20; f++) begin
            mode = 2'($urandom_range(0, 2));
            tdata = 8'($urandom); mlb = 1'($urandom); resp = 8'($urandom);
            pulse_start();
            for (int i = 0; i < 40; i++) begin
                start = ($urandom_range(0, 3) == 0);
                tdata = 8'($urandom); mlb = 1'($urandom); resp = 8'($urandom);
                cycle();
            end
            start = 1'b0;
            wait_idle(200);
            repeat (int'($urandom_range(1, 4))) cycle();
        end

        // Asynchronous reset after the 4th sck rise.
        clr_mon();
        mode = MODE_LOOP; mlb = 1'b1; tdata = 8'h5A;
        pulse_start();
        n = 0;
        while (mon_rise[0] < 4 && n < 200) begin
            cycle();
            n++;
        end
        check("t7_reach_rise4", 0, 8'(mon_rise[0]), 8'd4);
        #2;
        rstb = 1'b0;
        #1;
        check("t7_rst_ss", 0, 8'(w_ss[0]), 8'd1);
        check("t7_rst_sck", 0, 8'(w_sck[0]), 8'd1);
        check("t7_rst_busy", 0, 8'(w_busy[0]), 8'd0);
        for (int g = 0; g < 3; g++) check("t7_rst_rdata", g, w_rdata[g], 8'h00);
        repeat (3) cycle();
        check("t7_no_done", 0, 8'(mon_done[0]), 8'd0);
        rstb = 1'b1;
        repeat (2) cycle();
        clr_mon();
        tdata = 8'h96;
        pulse_start();
        wait_idle(200);
        check("t7_done", 0, 8'(mon_done[0]), 8'd1);
        check("t7_rdata", 0, w_rdata[0], 8'h96);
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master that generates ss/sck/sdout frames for the SPI_slave byte interface and captures its sdout on sdin.
- Sits directly upstream of the slave: a host loads a byte, pulses start, and receives the full-duplex response byte with a done pulse.
- Frame format matches the slave: sck idles high; master drives data after the sck falling edge; both ends sample on the sck rising edge. mlb selects MSB-first (1) or LSB-first (0).

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period; legal range 1..255.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rstb, input, 1: asynchronous active-low reset.
- start, input, 1: request a transfer; sampled only in IDLE.
- tdata, input, 8: byte to transmit; latched on the accepted start.
- mlb, input, 1: bit order, 1 = MSB first, 0 = LSB first; latched on the accepted start.
- sdin, input, 1: serial data from the slave's sdout.
- ss, output, 1: slave select, active low.
- sck, output, 1: serial clock, idle high.
- sdout, output, 1: serial data to the slave's sdin.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse at the end of a frame.
- rdata, output, 8: received byte; updated in the done cycle and held until the next done.

Behaviour:
- Reset (rstb=0, asynchronous, effective at any time including mid-frame): ss=1, sck=1, sdout=0, busy=0, done=0, rdata=8'h00, state=IDLE, all counters=0. Any partial frame is discarded.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE.
- A divider counter runs 0..CLK_DIV-1 in every non-IDLE, non-DONE state. The state advances when the counter reaches CLK_DIV-1.
- IDLE: ss=1, sck=1, busy=0. On start=1, latch tdata into the shift register and latch mlb, then go to SETUP. ss drops low on the same clock edge.
- SETUP: lasts CLK_DIV cycles; ss=0, sck=1. Gives the slave setup time before the first falling edge.
- SHIFT_LO: entering it drives sck=0 and presents the current tx bit on sdout. The tx bit is sr[7] when mlb=1 and sr[0] when mlb=0. Lasts CLK_DIV cycles, then goes to SHIFT_HI.
- SHIFT_HI, on the entry edge:
  - sck=1.
  - Capture sdin into the rx shift register: shift left with sdin into bit 0 when mlb=1; shift right with sdin into bit 7 when mlb=0.
  - Increment the 3-bit bit counter.
  - Lasts CLK_DIV cycles. Afterwards go to SHIFT_LO if fewer than 8 bits are done, otherwise HOLD.
- The tx shift register shifts in the same direction as rx once per bit, on the SHIFT_HI entry edge.
- HOLD: lasts CLK_DIV cycles; ss=0, sck=1; sdout holds its last value.
- DONE: one cycle. ss=1, done=1, busy=1, rdata <= rx register, sdout=0. Then go to IDLE.
- Frame timing: ss is low for exactly 18*CLK_DIV clk cycles. There are exactly 8 sck falling and 8 rising edges per frame. The first sck fall comes CLK_DIV cycles after ss falls.
- start is ignored while busy=1, including the DONE cycle. The earliest back-to-back start is accepted the cycle after done; the minimum ss-high gap is 2 cycles.
- tdata/mlb changes after start acceptance have no effect on the current frame.
- sdin is sampled exactly once per bit, at the clk edge that raises sck. No metastability synchroniser is needed: sdin comes from a slave clocked by our sck.

Test Plan:
- CLK_DIV=4, sdin looped to sdout, mlb=1, tdata=8'h7C, start pulse -> sdout sequence at rising sck edges is 0,1,1,1,1,1,0,0; ss low for 72 cycles; done pulses once; rdata=8'h7C; busy high from accept through DONE.
- CLK_DIV=4, mlb=0, tdata=8'h70, slave model returning 8'hA5 -> sdout sequence is 0,0,0,0,1,1,1,0; rdata=8'hA5; the first bit received lands in rdata[0].
- CLK_DIV=1, mlb=1, tdata=8'hFF, sdin tied 0 -> ss low for 18 cycles; 8 full sck periods of 2 cycles; rdata=8'h00; done pulses once.
- Start held high continuously, CLK_DIV=2 -> frames repeat with exactly 2 ss-high cycles between them; start during SHIFT states never restarts or corrupts a frame; each frame's rdata matches loopback.
- rstb asserted after the 4th rising sck edge -> ss=1, sck=1, busy=0 immediately, with no clk edge required; rdata stays 8'h00; no done pulse. After release, a new start completes normally.
- tdata changed from 8'h3C to 8'hC3 mid-frame -> the transmitted byte is still 8'h3C.
